// File: rtl/control_pipeline.sv
// rtl/control_pipeline.sv - ID/EX, EX/MEM, MEM/WB control registers with branch resolve and retire count
module control_pipeline #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ValidD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [1:0]       ALUOpD,
    input  logic             ZeroE,
    input  logic             FlushE,
    input  logic             Stall,
    output logic             ALUSrcE,
    output logic [1:0]       ALUOpE,
    output logic             ResultSrcE0,
    output logic             RegWriteE,
    output logic             PCSrcE,
    output logic             MemWriteM,
    output logic             RegWriteM,
    output logic [1:0]       ResultSrcW,
    output logic             RegWriteW,
    output logic [CNT_W-1:0] RetiredW
);

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_e_t;

    ctrl_e_t          ctrl_d;
    ctrl_e_t          ctrl_e;
    logic             valid_m;
    logic             reg_write_m;
    logic [1:0]       result_src_m;
    logic             mem_write_m;
    logic             valid_w;
    logic             reg_write_w;
    logic [1:0]       result_src_w;
    logic [CNT_W-1:0] retired;

    // Invalid decode slots collapse to an all-zero bubble before entering EX.
    always_comb begin
        ctrl_d = '0;
        if (ValidD) begin
            ctrl_d.valid      = 1'b1;
            ctrl_d.reg_write  = RegWriteD;
            ctrl_d.result_src = ResultSrcD;
            ctrl_d.mem_write  = MemWriteD;
            ctrl_d.jump       = JumpD;
            ctrl_d.branch     = BranchD;
            ctrl_d.alu_src    = ALUSrcD;
            ctrl_d.alu_op     = ALUOpD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_e       <= '0;
            valid_m      <= 1'b0;
            reg_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            mem_write_m  <= 1'b0;
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
            retired      <= '0;
        end else if (!Stall) begin
            ctrl_e       <= FlushE ? '0 : ctrl_d;
            valid_m      <= ctrl_e.valid;
            reg_write_m  <= ctrl_e.reg_write;
            result_src_m <= ctrl_e.result_src;
            mem_write_m  <= ctrl_e.mem_write;
            valid_w      <= valid_m;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
            if (valid_w) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    assign ALUSrcE     = ctrl_e.alu_src;
    assign ALUOpE      = ctrl_e.alu_op;
    assign ResultSrcE0 = ctrl_e.result_src[0] & ctrl_e.valid;
    assign RegWriteE   = ctrl_e.reg_write & ctrl_e.valid;
    assign PCSrcE      = ctrl_e.valid & (ctrl_e.jump | (ctrl_e.branch & ZeroE));
    assign MemWriteM   = mem_write_m & valid_m;
    assign RegWriteM   = reg_write_m & valid_m;
    assign ResultSrcW  = result_src_w;
    assign RegWriteW   = reg_write_w & valid_w;
    assign RetiredW    = retired;

endmodule

// File: tb/tb_control_pipeline.sv
// tb/tb_control_pipeline.sv - scoreboard bench for control_pipeline with directed vectors
module tb_control_pipeline;

    logic       clk;
    logic       rst_n;
    logic       ValidD;
    logic       RegWriteD;
    logic [1:0] ResultSrcD;
    logic       MemWriteD;
    logic       JumpD;
    logic       BranchD;
    logic       ALUSrcD;
    logic [1:0] ALUOpD;
    logic       ZeroE;
    logic       FlushE;
    logic       Stall;
    logic       ALUSrcE;
    logic [1:0] ALUOpE;
    logic       ResultSrcE0;
    logic       RegWriteE;
    logic       PCSrcE;
    logic       MemWriteM;
    logic       RegWriteM;
    logic [1:0] ResultSrcW;
    logic       RegWriteW;
    logic [3:0] RetiredW;

    control_pipeline #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
        .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .ALUOpD(ALUOpD), .ZeroE(ZeroE),
        .FlushE(FlushE), .Stall(Stall),
        .ALUSrcE(ALUSrcE), .ALUOpE(ALUOpE), .ResultSrcE0(ResultSrcE0),
        .RegWriteE(RegWriteE), .PCSrcE(PCSrcE), .MemWriteM(MemWriteM),
        .RegWriteM(RegWriteM), .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW),
        .RetiredW(RetiredW)
    );

    // D word: {Valid, RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc, ALUOp[1:0]}
    localparam logic [9:0] NOP   = 10'b0_0_00_0_0_0_0_00;
    localparam logic [9:0] LW    = 10'b1_1_01_0_0_0_1_00;
    localparam logic [9:0] SW    = 10'b1_0_00_1_0_0_1_00;
    localparam logic [9:0] RT    = 10'b1_1_00_0_0_0_0_10;
    localparam logic [9:0] BEQ   = 10'b1_0_00_0_0_1_0_01;
    localparam logic [9:0] JAL   = 10'b1_1_10_0_1_0_0_00;
    localparam logic [9:0] GHOST = 10'b0_1_01_1_1_1_1_11;

    typedef struct {
        string       name;
        logic [14:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [14:0] act;
    int          compared = 0;
    int          mismatched = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ALUSrcE, ALUOpE, ResultSrcE0, RegWriteE, PCSrcE, MemWriteM, RegWriteM, ResultSrcW, RegWriteW, RetiredW}
    function automatic logic [14:0] ex(input int a, input int op, input int rs0, input int rwe,
                                       input int pc, input int mwm, input int rwm, input int rsw,
                                       input int rww, input int ret);
        return {1'(a), 2'(op), 1'(rs0), 1'(rwe), 1'(pc), 1'(mwm), 1'(rwm), 2'(rsw), 1'(rww), 4'(ret)};
    endfunction

    task automatic step(input string nm, input logic [9:0] d, input int z, input int fl,
                        input int st, input logic [14:0] e);
        exp_t item;
        @(negedge clk);
        {ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUOpD} = d;
        ZeroE  = 1'(z);
        FlushE = 1'(fl);
        Stall  = 1'(st);
        item.name = nm;
        item.exp  = e;
        sb.push_back(item);
    endtask

    always @(posedge clk or negedge rst_n) begin
        #1;
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            act = {ALUSrcE, ALUOpE, ResultSrcE0, RegWriteE, PCSrcE, MemWriteM, RegWriteM,
                   ResultSrcW, RegWriteW, RetiredW};
            compared++;
            if (act !== cur.exp) begin
                mismatched++;
                $display("FAIL %s: got %b required %b", cur.name, act, cur.exp);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t item;
        rst_n = 1'b0;
        {ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUOpD} = NOP;
        ZeroE = 1'b0; FlushE = 1'b0; Stall = 1'b0;

        step("reset_state", LW, 0, 0, 0, ex(0,0,0,0,0, 0,0,0,0, 0));
        @(posedge clk); #2; rst_n = 1'b1;

        step("load_e",   LW,  0, 0, 0, ex(1,0,1,1,0, 0,0,0,0, 0));
        step("load_m",   NOP, 0, 0, 0, ex(0,0,0,0,0, 0,1,0,0, 0));
        step("load_w",   NOP, 0, 0, 0, ex(0,0,0,0,0, 0,0,1,1, 0));
        step("load_ret", NOP, 0, 0, 0, ex(0,0,0,0,0, 0,0,0,0, 1));

        step("beq_taken",  BEQ, 1, 0, 0, ex(0,1,0,0,1, 0,0,0,0, 1));
        step("beq_not",    BEQ, 0, 0, 0, ex(0,1,0,0,0, 0,0,0,0, 1));
        step("jal_e",      JAL, 0, 0, 0, ex(0,0,0,1,1, 0,0,0,0, 1));
        step("jal_m",      NOP, 0, 0, 0, ex(0,0,0,0,0, 0,1,0,0, 2));
        step("jal_w",      NOP, 0, 0, 0, ex(0,0,0,0,0, 0,0,2,1, 3));
        step("jal_ret",    NOP, 0, 0, 0, ex(0,0,0,0,0, 0,0,0,0, 4));

        step("sw_flush_e", SW,  0, 1, 0, ex(0,0,0,0,0, 0,0,0,0, 4));
        step("sw_flush_m", NOP, 0, 0, 0, ex(0,0,0,0,0, 0,0,0,0, 4));
        step("sw_flush_w", NOP, 0, 0, 0, ex(0,0,0,0,0, 0,0,0,0, 4));

        step("sw_e",   SW,  0, 0, 0, ex(1,0,0,0,0, 0,0,0,0, 4));
        step("sw_m",   NOP, 0, 0, 0, ex(0,0,0,0,0, 1,0,0,0, 4));
        step("sw_w",   NOP, 0, 0, 0, ex(0,0,0,0,0, 0,0,0,0, 4));
        step("sw_ret", NOP, 0, 0, 0, ex(0,0,0,0,0, 0,0,0,0, 5));

        step("stall_ld", LW,  0, 0, 0, ex(1,0,1,1,0, 0,0,0,0, 5));
        step("stall_rt", RT,  0, 0, 0, ex(0,2,0,1,0, 0,1,0,0, 5));
        step("stall_1",  BEQ, 1, 0, 1, ex(0,2,0,1,0, 0,1,0,0, 5));
        step("stall_2",  SW,  0, 0, 1, ex(0,2,0,1,0, 0,1,0,0, 5));
        step("stall_fl", SW,  0, 1, 1, ex(0,2,0,1,0, 0,1,0,0, 5));
        step("flush_e",  SW,  0, 1, 0, ex(0,0,0,0,0, 0,1,1,1, 5));
        step("resume_w", NOP, 0, 0, 0, ex(0,0,0,0,0, 0,0,0,1, 6));
        step("stall_vw", NOP, 1, 0, 1, ex(0,0,0,0,0, 0,0,0,1, 6));
        step("resume_r", NOP, 0, 0, 0, ex(0,0,0,0,0, 0,0,0,0, 7));
        step("ghost",    GHOST, 1, 0, 0, ex(0,0,0,0,0, 0,0,0,0, 7));

        step("pre_rst_e", RT, 0, 0, 0, ex(0,2,0,1,0, 0,0,0,0, 7));
        step("pre_rst_m", LW, 0, 0, 0, ex(1,0,1,1,0, 0,1,0,0, 7));
        @(posedge clk); #3;
        item.name = "async_rst";
        item.exp  = ex(0,0,0,0,0, 0,0,0,0, 0);
        sb.push_back(item);
        rst_n = 1'b0;
        step("rst_held", NOP, 0, 0, 0, ex(0,0,0,0,0, 0,0,0,0, 0));
        @(posedge clk); #2; rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step($sformatf("wrap%0d", i), RT, 0, 0, 0,
                 ex(0,2,0,1,0, 0, (i >= 1) ? 1 : 0, 0, (i >= 2) ? 1 : 0, (i >= 3) ? i - 2 : 0));
        end
        step("drain_a", NOP, 0, 0, 0, ex(0,0,0,0,0, 0,1,0,1, 15));
        step("drain_b", NOP, 0, 0, 0, ex(0,0,0,0,0, 0,0,0,1, 0));
        step("wrap_end", NOP, 0, 0, 0, ex(0,0,0,0,0, 0,0,0,0, 1));

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
